sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Shares the single-port program/data SRAM (`ram_1p`, 1-cycle read latency) between the Ibex instruction and data interfaces, replacing ad-hoc fixed-priority gluing in FPGA top levels. Performs round-robin arbitration and checks each address against the SRAM window. Out-of-window requests get an error response without a RAM access. Each RAM response is steered back to the port that issued it, and the arbiter flags any RAM response that is missing or unexpected.

## Interface
- `MemStart`, 32'h0000_0000, base address of SRAM window.
- `MemSize`, 64*1024, window size in bytes, power of two; window mask = `MemSize-1`.

Ports:
- `clk_sys` in 1: system clock.
- `rst_sys_n` in 1: reset, asynchronous, active-low.
- `instr_req_i` in 1, `instr_addr_i` in 32: fetch request and byte address.
- `instr_gnt_o` out 1, `instr_rvalid_o` out 1, `instr_err_o` out 1, `instr_rdata_o` out 32: fetch handshake and response.
- `data_req_i` in 1, `data_we_i` in 1, `data_be_i` in 4, `data_addr_i` in 32, `data_wdata_i` in 32: LSU request.
- `data_gnt_o` out 1, `data_rvalid_o` out 1, `data_err_o` out 1, `data_rdata_o` out 32: LSU handshake and response.
- `mem_req_o` out 1, `mem_we_o` out 1, `mem_be_o` out 4, `mem_addr_o` out 32, `mem_wdata_o` out 32: to `ram_1p`.
- `mem_rvalid_i` in 1, `mem_rdata_i` in 32: from `ram_1p`.
- `proto_err_o` out 1: sticky flag for a RAM response mismatch.

## Operation
- **Hit test.** A request hits when `(addr & ~(MemSize-1)) == MemStart`.
- **Grant rule.** At most one grant per cycle.
  - If only one port requests, that port is granted.
  - If both request, the port not granted last time is granted.
  - Round-robin pointer `last_q`: 0 = instr, 1 = data. It updates only on a grant.
- **Hit path.** `mem_req_o` = 1 in the grant cycle. Address, we, be and wdata come from the winner. For instr, `mem_we_o` = 0 and `mem_be_o` = 4'hF.
- **Miss path.** The request is granted, `mem_req_o` stays 0, and an error response is queued.
- **Idle.** When no request is granted, all `mem_*` outputs are 0.
- **Response register**, loaded on every grant: `rsp_valid_q`, `rsp_port_q`, `rsp_err_q`.
  - Next cycle, assert `<port>_rvalid_o` for `rsp_port_q`, with `<port>_err_o` = `rsp_err_q`.
  - `<port>_rdata_o` = `mem_rdata_i` on a hit response and 0 on an error response.
  - The non-responding port sees rvalid = 0, err = 0, rdata = 0.
  - Writes also return rvalid; their rdata is don't-care but driven from `mem_rdata_i`.
- **Protocol check.**
  - `proto_err_o` sets when `rsp_valid_q & ~rsp_err_q & ~mem_rvalid_i` (missing response).
  - It also sets when `mem_rvalid_i` is high and no hit response is pending (spurious response).
  - It clears only on reset.
- **Back-to-back.** A grant and a response for a different transaction in the same cycle are allowed. The response register pipelines one transaction per cycle with no stall.

## Timing
- Grant is combinational: `gnt` in the same cycle as `req`, per the Ibex OBI-style protocol.
- Response (rvalid/err/rdata) arrives exactly 1 cycle after the grant, for hits and misses alike.
- Requests are held by the core until granted. A losing port waits; with both requesting continuously, grants alternate every cycle.
- Reset values:
  - all gnt, rvalid, err and `mem_*` outputs = 0;
  - rdata outputs = 0;
  - `proto_err_o` = 0;
  - `last_q` = 1, so instr wins the first contention.
- Reset asserted mid-transaction clears `rsp_valid_q`. The pending response is discarded with no rvalid after reset release.
- The grant logic depends only on current req/addr and `last_q`. It has no combinational path from `mem_rvalid_i`.

## Structure
- Package `sram_arb_pkg`:
  - `typedef enum logic {PortInstr = 1'b0, PortData = 1'b1} arb_port_e;`
  - `typedef struct packed {logic valid; arb_port_e port; logic err;} arb_rsp_t;`
- Single module. The 2-way round-robin is small enough to stay inline; no sub-module.

## Test plan
1. **Instr only.** `instr_req` at 0x80 for 4 cycles, RAM returns 0x0000_0013 → `instr_gnt` = 1 each cycle; `instr_rvalid` 1 cycle later with rdata 0x0000_0013; data port stays silent.
2. **Contention.** Both ports request continuously, data write 0x1000 wdata 0xDEAD_BEEF be 4'hF → grants alternate instr, data, instr, data starting with instr; RAM sees write at 0x1000 in cycle 2; `data_rvalid` in cycle 3.
3. **Out-of-range.** Data read at 0x2000_0000 → `data_gnt` = 1; `mem_req_o` = 0; next cycle `data_rvalid` = 1, `data_err` = 1, rdata 0; `last_q` updates.
4. **Byte write steering.** Data be 4'b0100, addr 0x0000_0102 → `mem_be_o` = 4'b0100 and `mem_addr_o` = 0x102 in the grant cycle.
5. **Reset mid-flight.** Grant instr, assert `rst_sys_n` = 0 before the response, release → no `instr_rvalid`; all outputs 0; next contention grants instr first.
6. **Protocol.** RAM model suppresses `mem_rvalid_i` for one hit → `proto_err_o` rises the next cycle and stays 1 until reset; a spurious `mem_rvalid_i` while idle also sets it.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the instr/data SRAM port arbiter.
package sram_arb_pkg;

    localparam logic [31:0] MEM_START_DEFAULT = 32'h0000_0000;
    localparam int unsigned MEM_SIZE_DEFAULT  = 64 * 1024;

    typedef enum logic {PortInstr = 1'b0, PortData = 1'b1} arb_port_e;

    typedef struct packed {
        logic      valid;
        arb_port_e port;
        logic      err;
    } arb_rsp_t;

    // Window test: the bits above the window size must match the base.
    function automatic logic addr_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
        return (addr & ~mask) == base;
    endfunction

endpackage

// File: rtl/sram_port_arbiter.sv
// Round-robin sharing of one single-port SRAM between the Ibex instr and data
// interfaces, with window checking and a sticky RAM-protocol error flag.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter logic [31:0] MemStart = MEM_START_DEFAULT,
    parameter int unsigned MemSize  = MEM_SIZE_DEFAULT
) (
    input  logic        clk_sys,
    input  logic        rst_sys_n,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic        instr_err_o,
    output logic [31:0] instr_rdata_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic        data_err_o,
    output logic [31:0] data_rdata_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    output logic        proto_err_o
);

    localparam logic [31:0] MemMask = 32'(MemSize - 1);

    arb_port_e   last_q, last_d;
    arb_rsp_t    rsp_q, rsp_d;
    logic        proto_err_q, proto_err_d;

    logic        instr_hit, data_hit;
    logic        gnt_instr, gnt_data;
    logic        rsp_hit;
    logic [31:0] rsp_rdata;

    assign instr_hit = addr_hit(instr_addr_i, MemStart, MemMask);
    assign data_hit  = addr_hit(data_addr_i, MemStart, MemMask);

    // Grant depends only on requests and the pointer, never on the RAM side.
    always_comb begin
        gnt_instr = 1'b0;
        gnt_data  = 1'b0;
        if (instr_req_i && data_req_i) begin
            if (last_q == PortData) gnt_instr = 1'b1;
            else                    gnt_data  = 1'b1;
        end else begin
            gnt_instr = instr_req_i;
            gnt_data  = data_req_i;
        end
    end

    assign instr_gnt_o = gnt_instr;
    assign data_gnt_o  = gnt_data;

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        last_d      = last_q;
        rsp_d       = '0;
        if (gnt_instr) begin
            last_d = PortInstr;
            rsp_d  = '{valid: 1'b1, port: PortInstr, err: ~instr_hit};
            if (instr_hit) begin
                mem_req_o  = 1'b1;
                mem_be_o   = 4'hF;
                mem_addr_o = instr_addr_i;
            end
        end else if (gnt_data) begin
            last_d = PortData;
            rsp_d  = '{valid: 1'b1, port: PortData, err: ~data_hit};
            if (data_hit) begin
                mem_req_o   = 1'b1;
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end
        end
    end

    // Error responses never touched the RAM, so they return zero data.
    assign rsp_hit   = rsp_q.valid & ~rsp_q.err;
    assign rsp_rdata = rsp_hit ? mem_rdata_i : 32'h0;

    assign instr_rvalid_o = rsp_q.valid & (rsp_q.port == PortInstr);
    assign instr_err_o    = instr_rvalid_o & rsp_q.err;
    assign instr_rdata_o  = instr_rvalid_o ? rsp_rdata : 32'h0;

    assign data_rvalid_o  = rsp_q.valid & (rsp_q.port == PortData);
    assign data_err_o     = data_rvalid_o & rsp_q.err;
    assign data_rdata_o   = data_rvalid_o ? rsp_rdata : 32'h0;

    // Missing response for a pending hit, or a response nobody asked for.
    always_comb begin
        proto_err_d = proto_err_q
                    | (rsp_hit & ~mem_rvalid_i)
                    | (mem_rvalid_i & ~rsp_hit);
    end

    assign proto_err_o = proto_err_q;

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            last_q      <= PortData;
            rsp_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            last_q      <= last_d;
            rsp_q       <= rsp_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: RAM model, grant/response scoreboard.
module tb_sram_port_arbiter;

    logic        clk_sys = 1'b0;
    logic        rst_sys_n = 1'b0;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = 32'h0;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = 4'h0;
    logic [31:0] data_addr_i = 32'h0;
    logic [31:0] data_wdata_i = 32'h0;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        proto_err_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        port;
        logic        err;
        logic        chk_data;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic        m_last = 1'b1;
    logic [31:0] ram [0:16383];
    logic        suppress_rvalid = 1'b0;
    logic        spurious_rvalid = 1'b0;

    sram_port_arbiter dut (
        .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_err_o(instr_err_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_err_o(data_err_o), .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .proto_err_o(proto_err_o)
    );

    initial forever #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys); #1;
    endtask

    task automatic mid();
        @(negedge clk_sys); #1;
    endtask

    task automatic drop_reqs();
        instr_req_i = 1'b0;
        data_req_i  = 1'b0;
        data_we_i   = 1'b0;
        data_be_i   = 4'h0;
    endtask

    task automatic do_reset();
        drop_reqs();
        rst_sys_n = 1'b0;
        step();
        step();
        rst_sys_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_ignt"}, instr_gnt_o, 1'b0);
        chk1({tag, "_dgnt"}, data_gnt_o, 1'b0);
        chk1({tag, "_irvalid"}, instr_rvalid_o, 1'b0);
        chk1({tag, "_drvalid"}, data_rvalid_o, 1'b0);
        chk1({tag, "_ierr"}, instr_err_o, 1'b0);
        chk1({tag, "_derr"}, data_err_o, 1'b0);
        chk({tag, "_irdata"}, instr_rdata_o, 32'h0);
        chk({tag, "_drdata"}, data_rdata_o, 32'h0);
        chk1({tag, "_mreq"}, mem_req_o, 1'b0);
        chk1({tag, "_mwe"}, mem_we_o, 1'b0);
        chk({tag, "_mbe"}, {28'h0, mem_be_o}, 32'h0);
        chk({tag, "_maddr"}, mem_addr_o, 32'h0);
        chk({tag, "_mwdata"}, mem_wdata_o, 32'h0);
        chk1({tag, "_proto"}, proto_err_o, 1'b0);
    endtask

    // 1-cycle-latency single-port RAM with fault injection knobs.
    always @(posedge clk_sys) begin
        mem_rvalid_i <= (mem_req_o & ~suppress_rvalid) | spurious_rvalid;
        mem_rdata_i  <= (mem_req_o && !mem_we_o) ? ram[mem_addr_o[15:2]] : 32'h0;
        if (mem_req_o && mem_we_o)
            for (int b = 0; b < 4; b++)
                if (mem_be_o[b]) ram[mem_addr_o[15:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    end

    // Scoreboard: model grants, push expected responses, pop one cycle later.
    always @(negedge clk_sys) begin
        exp_t        e;
        logic        wi, wd, hit;
        logic [31:0] a;
        if (!rst_sys_n) begin
            sb.delete();
            m_last = 1'b1;
        end else begin
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk1("rsp_instr_rvalid", instr_rvalid_o, e.port == 1'b0);
                chk1("rsp_data_rvalid", data_rvalid_o, e.port);
                chk1("rsp_instr_err", instr_err_o, !e.port && e.err);
                chk1("rsp_data_err", data_err_o, e.port && e.err);
                if (e.chk_data)
                    chk("rsp_rdata", e.port ? data_rdata_o : instr_rdata_o, e.rdata);
                chk("rsp_other_rdata", e.port ? instr_rdata_o : data_rdata_o, 32'h0);
            end else begin
                chk1("idle_instr_rvalid", instr_rvalid_o, 1'b0);
                chk1("idle_data_rvalid", data_rvalid_o, 1'b0);
                chk1("idle_instr_err", instr_err_o, 1'b0);
                chk1("idle_data_err", data_err_o, 1'b0);
            end
            if (instr_req_i && data_req_i) begin
                wi = m_last;
                wd = !m_last;
            end else begin
                wi = instr_req_i;
                wd = data_req_i;
            end
            chk1("instr_gnt", instr_gnt_o, wi);
            chk1("data_gnt", data_gnt_o, wd);
            a   = wd ? data_addr_i : instr_addr_i;
            hit = (a[31:16] == 16'h0);
            if (wi || wd) begin
                chk1("mem_req", mem_req_o, hit);
                if (hit) begin
                    chk("mem_addr", mem_addr_o, a);
                    chk1("mem_we", mem_we_o, wd && data_we_i);
                    chk("mem_be", {28'h0, mem_be_o}, {28'h0, (wd ? data_be_i : 4'hF)});
                    if (wd && data_we_i) chk("mem_wdata", mem_wdata_o, data_wdata_i);
                end
                e.port     = wd;
                e.err      = !hit;
                e.chk_data = !hit || !(wd && data_we_i);
                e.rdata    = hit ? ram[a[15:2]] : 32'h0;
                sb.push_back(e);
                m_last = wd;
            end else begin
                chk1("idle_mem_req", mem_req_o, 1'b0);
                chk1("idle_mem_we", mem_we_o, 1'b0);
                chk("idle_mem_addr", mem_addr_o, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16384; i++) ram[i] = {16'hC0DE, 16'(i)};
        ram[32] = 32'h0000_0013;

        // Reset state
        step();
        mid();
        chk_all_zero("reset");
        step();
        rst_sys_n = 1'b1;

        // Instr only, 4 back-to-back fetches
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h80;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk1("t1_ignt", instr_gnt_o, 1'b1);
            chk1("t1_dgnt", data_gnt_o, 1'b0);
            chk1("t1_drvalid", data_rvalid_o, 1'b0);
            if (i > 0) chk("t1_irdata", instr_rdata_o, 32'h0000_0013);
            step();
        end
        drop_reqs();
        mid();
        chk1("t1_last_rvalid", instr_rvalid_o, 1'b1);
        chk("t1_last_rdata", instr_rdata_o, 32'h0000_0013);
        step();

        // Contention from reset: instr, data, instr, data
        do_reset();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h84;
        data_req_i   = 1'b1;
        data_we_i    = 1'b1;
        data_be_i    = 4'hF;
        data_addr_i  = 32'h1000;
        data_wdata_i = 32'hDEAD_BEEF;
        mid();
        chk1("t2_c1_ignt", instr_gnt_o, 1'b1);
        chk1("t2_c1_dgnt", data_gnt_o, 1'b0);
        step();
        mid();
        chk1("t2_c2_dgnt", data_gnt_o, 1'b1);
        chk1("t2_c2_mwe", mem_we_o, 1'b1);
        chk("t2_c2_maddr", mem_addr_o, 32'h1000);
        chk("t2_c2_mwdata", mem_wdata_o, 32'hDEAD_BEEF);
        step();
        mid();
        chk1("t2_c3_drvalid", data_rvalid_o, 1'b1);
        chk1("t2_c3_ignt", instr_gnt_o, 1'b1);
        step();
        mid();
        chk1("t2_c4_dgnt", data_gnt_o, 1'b1);
        step();
        drop_reqs();
        step();

        // Out-of-range data read; pointer must still move to data
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h84;
        step();
        drop_reqs();
        data_req_i  = 1'b1;
        data_addr_i = 32'h2000_0000;
        mid();
        chk1("t3_dgnt", data_gnt_o, 1'b1);
        chk1("t3_mreq", mem_req_o, 1'b0);
        step();
        drop_reqs();
        mid();
        chk1("t3_drvalid", data_rvalid_o, 1'b1);
        chk1("t3_derr", data_err_o, 1'b1);
        chk("t3_drdata", data_rdata_o, 32'h0);
        step();
        instr_req_i = 1'b1;
        data_req_i  = 1'b1;
        data_addr_i = 32'h80;
        mid();
        chk1("t3_rr_ignt", instr_gnt_o, 1'b1);
        step();
        drop_reqs();
        step();

        // Byte write steering
        data_req_i   = 1'b1;
        data_we_i    = 1'b1;
        data_be_i    = 4'b0100;
        data_addr_i  = 32'h0000_0102;
        data_wdata_i = 32'h00AB_0000;
        mid();
        chk("t4_mbe", {28'h0, mem_be_o}, 32'h4);
        chk("t4_maddr", mem_addr_o, 32'h102);
        step();
        drop_reqs();
        step();

        // Reset mid-flight: pending response must vanish
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h88;
        mid();
        chk1("t5_ignt", instr_gnt_o, 1'b1);
        rst_sys_n = 1'b0;
        drop_reqs();
        mid();
        chk_all_zero("t5_inreset");
        step();
        rst_sys_n = 1'b1;
        mid();
        chk1("t5_no_rvalid", instr_rvalid_o, 1'b0);
        step();
        instr_req_i = 1'b1;
        data_req_i  = 1'b1;
        data_addr_i = 32'h90;
        mid();
        chk1("t5_rr_ignt", instr_gnt_o, 1'b1);
        chk1("t5_rr_dgnt", data_gnt_o, 1'b0);
        step();
        drop_reqs();
        step();

        // Protocol: missing response, then spurious response
        mid();
        chk1("t6_proto_clean", proto_err_o, 1'b0);
        step();
        instr_req_i     = 1'b1;
        instr_addr_i    = 32'h8C;
        suppress_rvalid = 1'b1;
        step();
        drop_reqs();
        suppress_rvalid = 1'b0;
        mid();
        chk1("t6_proto_before", proto_err_o, 1'b0);
        step();
        mid();
        chk1("t6_proto_set", proto_err_o, 1'b1);
        step();
        step();
        mid();
        chk1("t6_proto_sticky", proto_err_o, 1'b1);
        do_reset();
        mid();
        chk1("t6_proto_cleared", proto_err_o, 1'b0);
        step();
        spurious_rvalid = 1'b1;
        step();
        spurious_rvalid = 1'b0;
        mid();
        chk1("t6_spur_before", proto_err_o, 1'b0);
        step();
        mid();
        chk1("t6_spur_set", proto_err_o, 1'b1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
